// File: rtl/conv_pkg.sv
// Shared definitions for the convolution host memory: layer select codes,
// bank depths and the host FSM state type.
package conv_pkg;

  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2   = 3'd5;

  localparam int DEPTH_L0K0 = 4096;
  localparam int DEPTH_L0K1 = 4096;
  localparam int DEPTH_L1K0 = 1024;
  localparam int DEPTH_L1K1 = 1024;
  localparam int DEPTH_L2   = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DUMP
  } state_t;

  // Depth of the bank behind a select code; 0 marks "no memory".
  function automatic int bank_depth(input logic [2:0] sel);
    case (sel)
      CSEL_L0K0: return DEPTH_L0K0;
      CSEL_L0K1: return DEPTH_L0K1;
      CSEL_L1K0: return DEPTH_L1K0;
      CSEL_L1K1: return DEPTH_L1K1;
      CSEL_L2:   return DEPTH_L2;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/layer_bank.sv
// Single memory bank: one write port, one combinational read port and one
// registered read port. Contents are never reset.
module layer_bank #(
  parameter int DEPTH = 1024,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata,
  input  logic [AW-1:0]        sraddr,
  output logic signed [DW-1:0] srdata
);

  localparam int IW = $clog2(DEPTH);

  logic signed [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    srdata <= mem[sraddr[IW-1:0]];
  end

  assign rdata = mem[raddr[IW-1:0]];

  // Range checking happens in the caller, so the high address bits are not needed here.
  if (IW < AW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{waddr[AW-1:IW], raddr[AW-1:IW], sraddr[AW-1:IW]};
  end

endmodule

// File: rtl/conv_mem_host.sv
// Host-side memory for the convolution accelerator: image load, start
// handshake, accelerator-side bank access and result dump.
module conv_mem_host
  import conv_pkg::*;
#(
  parameter int DW        = 20,
  parameter int AW        = 12,
  parameter int IMG_WORDS = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic [2:0]           dump_sel,
  output logic                 ready,
  input  logic                 busy,
  input  logic [AW-1:0]        iaddr,
  output logic signed [DW-1:0] idata,
  input  logic                 cwr,
  input  logic [AW-1:0]        caddr_wr,
  input  logic signed [DW-1:0] cdata_wr,
  input  logic                 crd,
  input  logic [AW-1:0]        caddr_rd,
  output logic signed [DW-1:0] cdata_rd,
  input  logic [2:0]           csel,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last,
  output logic                 done,
  output logic                 err
);

  state_t               state, state_nxt;
  logic [AW-1:0]        pix_cnt;
  logic [AW-1:0]        beat;
  logic [2:0]           dsel;
  logic                 vld_p1;
  logic                 done_q, err_q;

  logic                 acc_en, s_fire, load_last;
  logic [AW:0]          depth_wr, depth_rd, dump_depth;
  logic                 wr_in_range, rd_in_range, wr_ok, rd_ok, acc_err;
  logic                 dump_sel_ok, last_beat, dump_end;
  logic [AW-1:0]        rd_addr_p0;
  logic signed [DW-1:0] dump_rd_p1;
  logic signed [DW-1:0] img_srd_unused;
  logic signed [DW-1:0] lyr_rd  [1:5];
  logic signed [DW-1:0] lyr_srd [1:5];

  assign acc_en    = (state == ST_START) || (state == ST_RUN);
  assign s_ready   = !reset && ((state == ST_IDLE) || (state == ST_LOAD));
  assign s_fire    = s_valid && s_ready;
  assign load_last = (state == ST_LOAD) && s_fire && (pix_cnt == AW'(IMG_WORDS - 1));

  // An unknown select has depth 0, so the range test also rejects it.
  assign depth_wr    = (AW+1)'(bank_depth(csel));
  assign depth_rd    = (AW+1)'(bank_depth(csel));
  assign wr_in_range = {1'b0, caddr_wr} < depth_wr;
  assign rd_in_range = {1'b0, caddr_rd} < depth_rd;
  assign wr_ok       = acc_en && cwr && !crd && wr_in_range;
  assign rd_ok       = acc_en && crd && rd_in_range;
  assign acc_err     = acc_en && ((cwr && crd) || (cwr && !wr_in_range) || (crd && !rd_in_range));

  assign dump_depth  = (AW+1)'(bank_depth(dsel));
  assign dump_sel_ok = dump_depth != '0;
  assign last_beat   = {1'b0, beat} == (dump_depth - 1'b1);
  assign dump_end    = (state == ST_DUMP) && vld_p1 && m_ready && last_beat;

  // Stage p0: address presented to the registered read port; it repeats the
  // current beat while stalled so the output word stays put.
  assign rd_addr_p0 = (vld_p1 && m_ready) ? beat + 1'b1 : beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (s_fire) state_nxt = ST_LOAD;
      ST_LOAD:  if (load_last) state_nxt = ST_START;
      ST_START: if (busy) state_nxt = ST_RUN;
      ST_RUN:   if (!busy) state_nxt = dump_sel_ok ? ST_DUMP : ST_IDLE;
      ST_DUMP:  if (dump_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
      beat    <= '0;
      dsel    <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (s_fire) pix_cnt <= load_last ? '0 : pix_cnt + 1'b1;
      if ((state == ST_IDLE) && s_fire) begin
        dsel  <= dump_sel;
        err_q <= 1'b0;
      end else if (acc_err) begin
        err_q <= 1'b1;
      end
      if ((state == ST_RUN) && !busy && !dump_sel_ok) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      // Stage p1: registered dump word and its valid.
      if (state == ST_DUMP) begin
        if (!vld_p1) begin
          vld_p1 <= 1'b1;
        end else if (m_ready) begin
          if (last_beat) begin
            vld_p1 <= 1'b0;
            beat   <= '0;
            done_q <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
      end
    end
  end

  layer_bank #(.DEPTH(IMG_WORDS), .DW(DW), .AW(AW)) u_img (
    .clk   (clk),
    .we    (s_fire),
    .waddr (pix_cnt),
    .wdata (s_data),
    .raddr (iaddr),
    .rdata (idata),
    .sraddr(iaddr),
    .srdata(img_srd_unused)
  );

  for (genvar g = 1; g <= 5; g++) begin : g_lyr
    layer_bank #(.DEPTH(bank_depth(3'(g))), .DW(DW), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (wr_ok && (csel == 3'(g))),
      .waddr (caddr_wr),
      .wdata (cdata_wr),
      .raddr (caddr_rd),
      .rdata (lyr_rd[g]),
      .sraddr(rd_addr_p0),
      .srdata(lyr_srd[g])
    );
  end

  always_comb begin
    cdata_rd   = '0;
    dump_rd_p1 = '0;
    for (int i = 1; i <= 5; i++) begin
      if (rd_ok && (csel == 3'(i))) cdata_rd = lyr_rd[i];
      if (dsel == 3'(i)) dump_rd_p1 = lyr_srd[i];
    end
  end

  assign m_valid = vld_p1;
  assign m_last  = vld_p1 && last_beat;
  assign m_data  = vld_p1 ? dump_rd_p1 : '0;
  assign ready   = (state == ST_START);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: load, start handshake, bank access,
// error cases, dumps with and without back-pressure, reset abort.
module tb_conv_mem_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [19:0] s_data = '0;
  logic [2:0]  dump_sel = '0;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic [2:0]  csel = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [19:0] m_data;
  logic        m_last;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_bad = 0;

  conv_mem_host dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .dump_sel(dump_sel),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input logic [2:0] sel);
    dump_sel = sel;
    s_valid  = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      s_data = 20'(k);
      if (k == 2000) begin
        chk("load_sready", 32'(s_ready), 32'd1);
        chk("load_ready_low", 32'(ready), 32'd0);
      end
      step();
    end
    s_valid  = 1'b0;
    dump_sel = '0;
    chk("start_ready", 32'(ready), 32'd1);
    chk("start_sready", 32'(s_ready), 32'd0);
  endtask

  task automatic wr(input logic [2:0] sel, input int addr, input logic [19:0] data);
    cwr = 1'b1; csel = sel; caddr_wr = 12'(addr); cdata_wr = data;
    step();
    cwr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] sel, input int addr,
                        input logic [19:0] exp);
    crd = 1'b1; csel = sel; caddr_rd = 12'(addr);
    #1;
    chk(tag, 32'(cdata_rd), 32'(exp));
    crd = 1'b0;
  endtask

  // Entered in the first DUMP cycle; expected word idx is idx*mul+add.
  task automatic dump_collect(input int n, input bit toggle, input int mul, input int add);
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    logic [19:0] exp;
    while (idx < n && cyc < 20000) begin
      m_ready = toggle ? cyc[0] : 1'b1;
      if (m_valid) begin
        exp = 20'(idx * mul + add);
        if (m_data !== exp || m_last !== (idx == n - 1)) begin
          bad++;
          if (bad <= 4)
            $display("FAIL dump_beat %0d: got=0x%0h last=%0b exp=0x%0h", idx, m_data, m_last, exp);
        end
        if (m_ready) idx++;
      end
      step();
      cyc++;
    end
    m_ready = 1'b0;
    chk("dump_beats", 32'(idx), 32'(n));
    chk("dump_bad_beats", 32'(bad), 32'd0);
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_mvalid_off", 32'(m_valid), 32'd0);
    step();
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(posedge clk);
    #1;
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_sready", 32'(s_ready), 32'd1);

    // Job 1: ramp load, handshake, bank access, full L2 dump
    load_image(3'd5);
    iaddr = 12'd4095;
    #1;
    chk("idata_4095", 32'(idata), 32'd4095);
    iaddr = 12'd100;
    #1;
    chk("idata_100", 32'(idata), 32'd100);
    repeat (3) step();
    chk("ready_hold", 32'(ready), 32'd1);
    busy = 1'b1;
    step();
    chk("ready_drop", 32'(ready), 32'd0);
    wr(3'd4, 5, 20'h12345);
    wr(3'd3, 5, 20'h0ABCD);
    rd_chk("raw_l1k0", 3'd3, 5, 20'h0ABCD);
    rd_chk("other_bank_l1k1", 3'd4, 5, 20'h12345);
    csel = 3'd3; caddr_rd = 12'd5;
    #1;
    chk("no_strobe_zero", 32'(cdata_rd), 32'd0);
    step();
    wr(3'd1, 7, 20'h00777);
    wr(3'd2, 4000, 20'h04444);
    for (int a = 0; a < 2048; a++) wr(3'd5, a, 20'(a));
    chk("job1_err_clear", 32'(err), 32'd0);
    busy = 1'b0;
    step();
    chk("dump_first_gap", 32'(m_valid), 32'd0);
    dump_collect(2048, 1'b0, 1, 0);

    // Job 2: out-of-range accesses, dump of L1 kernel0 under back-pressure
    rd_chk("idle_read_zero", 3'd3, 5, 20'h0);
    load_image(3'd3);
    busy = 1'b1;
    step();
    for (int a = 0; a < 1024; a++) wr(3'd3, a, 20'(a * 3 + 7));
    chk("job2_err_pre", 32'(err), 32'd0);
    wr(3'd3, 1024, 20'hFFFFF);
    chk("oob_write_err", 32'(err), 32'd1);
    rd_chk("oob_no_wrap", 3'd3, 0, 20'd7);
    rd_chk("oob_read_zero", 3'd3, 1024, 20'h0);
    rd_chk("bad_sel_read_zero", 3'd6, 0, 20'h0);
    busy = 1'b0;
    step();
    chk("dump2_first_gap", 32'(m_valid), 32'd0);
    dump_collect(1024, 1'b1, 3, 7);

    // Job 3: simultaneous write and read, dump_sel 7
    load_image(3'd7);
    chk("err_cleared_by_load", 32'(err), 32'd0);
    busy = 1'b1;
    step();
    wr(3'd4, 9, 20'h0F0F0);
    cwr = 1'b1; crd = 1'b1; csel = 3'd4; caddr_wr = 12'd9; caddr_rd = 12'd9;
    cdata_wr = 20'h55555;
    #1;
    chk("same_cycle_old", 32'(cdata_rd), 32'h0F0F0);
    chk("wrrd_err_pre", 32'(err), 32'd0);
    step();
    chk("wrrd_err", 32'(err), 32'd1);
    cwr = 1'b0;
    #1;
    chk("wr_suppressed", 32'(cdata_rd), 32'h0F0F0);
    crd = 1'b0;
    busy = 1'b0;
    step();
    chk("sel7_done", 32'(done), 32'd1);
    chk("sel7_no_dump", 32'(m_valid), 32'd0);
    chk("sel7_idle", 32'(s_ready), 32'd1);
    step();
    chk("sel7_done_pulse", 32'(done), 32'd0);

    // Job 4: dump_sel 6 with no accelerator errors
    load_image(3'd6);
    busy = 1'b1;
    step();
    step();
    chk("sel6_err_pre", 32'(err), 32'd0);
    busy = 1'b0;
    step();
    chk("sel6_done", 32'(done), 32'd1);
    chk("sel6_err", 32'(err), 32'd1);
    chk("sel6_no_dump", 32'(m_valid), 32'd0);
    step();
    chk("sel6_done_pulse", 32'(done), 32'd0);
    chk("sel6_err_sticky", 32'(err), 32'd1);

    // Job 5: reset during RUN with a pending stream word
    load_image(3'd1);
    busy = 1'b1;
    step();
    s_valid = 1'b1;
    s_data  = 20'h3;
    reset   = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_mvalid", 32'(m_valid), 32'd0);
    chk("abort_sready", 32'(s_ready), 32'd0);
    step();
    reset   = 1'b0;
    s_valid = 1'b0;
    busy    = 1'b0;
    #1;
    chk("abort_idle_sready", 32'(s_ready), 32'd1);
    chk("abort_err", 32'(err), 32'd0);

    // Job 6: fresh load; earlier layer contents persist across reset
    load_image(3'd5);
    busy = 1'b1;
    step();
    rd_chk("persist_l0k0", 3'd1, 7, 20'h00777);
    rd_chk("persist_l0k1", 3'd2, 4000, 20'h04444);
    busy = 1'b0;
    step();
    dump_collect(2048, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
